io_input_conditioner: RTL and testbench
=======================================

// Module: io_input_conditioner
// PURPOSE
//  Front end for the board's raw switch and push-button pins, placed upstream of
//  wrapper_processor. Provides:
//  - 2-flop synchronisation and per-bit debounce on all inputs.
//  - Clean switch and button levels, driven into the processor's i_io_sw / i_io_btn.
//  - One-cycle button rising-edge pulses.
//  - Sticky per-button event flags that firmware clears.
// PARAMETERS
//  NUM_SW          32       number of slide switches
//  NUM_BTN         4        number of push buttons
//  DEBOUNCE_CYCLES 500_000  cycles input must be stable before output follows (>=1; 10 ms @ 50 MHz)
//  BTN_ACTIVE_LOW  0        1: invert raw buttons after sync so outputs are always active-high
// PORTS
//  i_clk        in   1        system clock
//  i_rst_n      in   1        asynchronous active-low reset
//  i_sw_raw     in   NUM_SW   raw switch pins, asynchronous
//  i_btn_raw    in   NUM_BTN  raw button pins, asynchronous
//  i_evt_clr    in   NUM_BTN  per-bit clear of o_btn_evt (level, sampled each cycle)
//  o_io_sw      out  NUM_SW   debounced switch levels
//  o_io_btn     out  NUM_BTN  debounced button levels, active-high
//  o_btn_rise   out  NUM_BTN  1-cycle pulse on debounced 0->1 of each button
//  o_btn_evt    out  NUM_BTN  sticky press flag per button
// BEHAVIOUR
//  - One clock domain. Reset is asynchronous and active-low.
//    All flops and outputs reset to 0: sync stages, counters, stable levels, o_btn_rise, o_btn_evt.
//  - Per bit (switch or button), synchronisation:
//    s1 <= raw; s2 <= s1.
//    Button bits are inverted after s2 when BTN_ACTIVE_LOW=1.
//  - Per bit, debounce counter cnt, width $clog2(DEBOUNCE_CYCLES+1):
//    - s2 == stable: cnt <= 0.
//    - s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
//    - Otherwise: cnt <= cnt + 1.
//    - Any reversion of s2 before terminal count resets cnt; a bounce never reaches the output.
//    - cnt never wraps.
//  - Latency: a raw change held steady is first visible on o_io_* after rising edge DEBOUNCE_CYCLES+2,
//    counted from the first edge that samples the new raw value.
//  - Edge detection: btn_q <= stable each cycle; o_btn_rise = registered (stable & ~btn_q).
//    - One pulse per debounced press.
//    - Falling edge produces no pulse.
//    - A held button gives no repeat pulses.
//  - o_btn_evt[i]:
//    - Set when stable rising edge of bit i is detected (same cycle o_btn_rise[i] asserts).
//    - Else cleared when i_evt_clr[i]=1.
//    - Set and clear in the same cycle: set wins.
//  - Bits are fully independent. Simultaneous changes on several bits resolve in the same cycle.
//  - Reset mid-count discards partial counts. After release, outputs reflect inputs only after a full debounce period.
// STRUCTURE
//  - Package io_pkg: NUM_SW, NUM_BTN defaults and DEBOUNCE_CYCLES default.
//    Shared with wrapper_processor so widths match.
//  - Sub-module debounce_bit: one bit of sync + counter + stable flop, parameter DEBOUNCE_CYCLES.
//    Instantiated NUM_SW + NUM_BTN times via generate.
//  - Top holds inversion, edge detect, and event flags.
// TESTING (DEBOUNCE_CYCLES=4, 10 ns clock)
//  1. Reset: i_rst_n=0 with raw inputs nonzero -> all outputs 0. Outputs stay 0 until 6 edges after release with inputs steady.
//  2. Bounce: i_btn_raw=4'h8 for 3 cycles, then 0 -> o_io_btn, o_btn_rise, o_btn_evt never leave 0.
//  3. Clean press: i_btn_raw=4'h8 held ->
//     - o_io_btn=4'h8 after edge 6.
//     - o_btn_rise=4'h8 for exactly one cycle.
//     - o_btn_evt=4'h8 until i_evt_clr=4'h8 for 1 cycle, then 0.
//  4. Simultaneous change: from 4'h8 held, raw -> 4'h6 ->
//     - o_io_btn goes 4'h8 -> 4'h6 in one cycle.
//     - o_btn_rise=4'h6 for one cycle.
//     - No pulse on bit 3.
//  5. Clear vs set collision: i_evt_clr=4'h2 asserted in the cycle bit 1 rises -> o_btn_evt[1] remains 1.
//  6. Switches and reset mid-count:
//     - i_sw_raw=32'hA5A5_0001 steady -> o_io_sw equals it after edge 6.
//     - Pulse i_rst_n low at edge 4 of a change -> o_io_sw=0 immediately, then the value reappears 6 edges after release.

Source files
------------

// File: rtl/io_pkg.sv
// Shared widths and timing defaults for the board I/O front end.
// The processor wrapper imports this package too, so the pin widths agree on both sides.
package io_pkg;

  localparam int unsigned DEF_NUM_SW          = 32;
  localparam int unsigned DEF_NUM_BTN         = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;  // 10 ms at 50 MHz

  // Width of a counter that must hold the values 0 .. cycles.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchroniser, optional polarity flip, stability counter and clean level.
// The clean level follows the synchronised input only after DEBOUNCE_CYCLES steady cycles.
module debounce_bit
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          INVERT          = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int unsigned          CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             level;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign level = s2_q ^ INVERT;

  // The counter restarts whenever the input agrees with the clean level, so a
  // bounce shorter than the full period never reaches the terminal count.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (level == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = level;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      s1_q     <= i_raw;
      s2_q     <= s1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign o_level = stable_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Switch/button front end: per-bit sync + debounce, button rise pulses and sticky press flags
// that firmware clears through i_evt_clr.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int unsigned NUM_SW          = DEF_NUM_SW,
  parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SW-1:0]  i_sw_raw,
  input  logic [NUM_BTN-1:0] i_btn_raw,
  input  logic [NUM_BTN-1:0] i_evt_clr,
  output logic [NUM_SW-1:0]  o_io_sw,
  output logic [NUM_BTN-1:0] o_io_btn,
  output logic [NUM_BTN-1:0] o_btn_rise,
  output logic [NUM_BTN-1:0] o_btn_evt
);

  logic [NUM_BTN-1:0] btn_stable;
  logic [NUM_BTN-1:0] btn_q;
  logic [NUM_BTN-1:0] rise_q, rise_d;
  logic [NUM_BTN-1:0] evt_q, evt_d;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (1'b0)
    ) u_db (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_raw  (i_sw_raw[i]),
      .o_level(o_io_sw[i])
    );
  end

  // Active-low buttons are flipped after synchronisation so everything downstream is active-high.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (BTN_ACTIVE_LOW)
    ) u_db (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_raw  (i_btn_raw[i]),
      .o_level(btn_stable[i])
    );
  end

  // A new press sets the flag even if firmware is clearing it in the same cycle.
  always_comb begin
    rise_d = btn_stable & ~btn_q;
    evt_d  = rise_d | (evt_q & ~i_evt_clr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_q  <= '0;
      rise_q <= '0;
      evt_q  <= '0;
    end else begin
      btn_q  <= btn_stable;
      rise_q <= rise_d;
      evt_q  <= evt_d;
    end
  end

  assign o_io_btn   = btn_stable;
  assign o_btn_rise = rise_q;
  assign o_btn_evt  = evt_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner with a 4-cycle debounce: hand-written reset/mid-count sequences,
// a per-cycle expectation table for button scenarios, and random traffic against a window model.
module tb_io_input_conditioner;

  localparam int unsigned NSW = 32;
  localparam int unsigned NBTN = 4;
  localparam int unsigned DEB = 4;
  localparam int unsigned NB = NSW + NBTN;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NSW-1:0]  sw_raw;
  logic [NBTN-1:0] btn_raw, evt_clr;
  logic [NSW-1:0]  io_sw;
  logic [NBTN-1:0] io_btn, btn_rise, btn_evt;

  always #5 clk = ~clk;

  io_input_conditioner #(
    .NUM_SW         (NSW),
    .NUM_BTN        (NBTN),
    .DEBOUNCE_CYCLES(DEB),
    .BTN_ACTIVE_LOW (1'b0)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_sw_raw  (sw_raw),
    .i_btn_raw (btn_raw),
    .i_evt_clr (evt_clr),
    .o_io_sw   (io_sw),
    .o_io_btn  (io_btn),
    .o_btn_rise(btn_rise),
    .o_btn_evt (btn_evt)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a bit's clean level takes value v once the synchronised input has read v
  // on each of the last DEB clock edges. Bits are packed as {buttons, switches}.
  logic [NB-1:0]   m_s1, m_s2, m_stable;
  logic [NB-1:0]   m_hist[DEB];
  logic [NBTN-1:0] m_btnq, m_rise, m_evt;

  function automatic void model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0;
    for (int i = 0; i < DEB; i++) m_hist[i] = '0;
    m_btnq = '0; m_rise = '0; m_evt = '0;
  endfunction

  function automatic void model_step();
    logic [NB-1:0]   ones, zeros;
    logic [NBTN-1:0] rise_n;
    for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = m_s2;
    ones  = '1;
    zeros = '1;
    for (int i = 0; i < DEB; i++) begin
      ones  &= m_hist[i];
      zeros &= ~m_hist[i];
    end
    rise_n   = m_stable[NB-1:NSW] & ~m_btnq;
    m_evt    = rise_n | (m_evt & ~evt_clr);
    m_rise   = rise_n;
    m_btnq   = m_stable[NB-1:NSW];
    m_stable = (m_stable | ones) & ~zeros;
    m_s2     = m_s1;
    m_s1     = {btn_raw, sw_raw};
  endfunction

  // One clock edge: advance the model, then sample the DUT 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    chk("model_sw", io_sw, m_stable[NSW-1:0]);
    chk("model_btn", 32'(io_btn), 32'(m_stable[NB-1:NSW]));
    chk("model_rise", 32'(btn_rise), 32'(m_rise));
    chk("model_evt", 32'(btn_evt), 32'(m_evt));
  endtask

  typedef struct {
    logic [NBTN-1:0] btn, clr, e_btn, e_rise, e_evt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [3:0] b, input logic [3:0] c, input logic [3:0] eb,
                              input logic [3:0] er, input logic [3:0] ee);
    vec_t v;
    v.btn = b; v.clr = c; v.e_btn = eb; v.e_rise = er; v.e_evt = ee;
    tbl.push_back(v);
  endfunction

  initial begin
    rst_n = 1'b0; sw_raw = '0; btn_raw = '0; evt_clr = '0;
    model_reset();

    // Bounce: three cycles high then low never reaches the output.
    for (int i = 0; i < 8; i++) add((i < 3) ? 4'h8 : 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // Clean press on bit 3, then a one-cycle clear.
    for (int i = 0; i < 5; i++) add(4'h8, 4'h0, 4'h0, 4'h0, 4'h0);
    add(4'h8, 4'h0, 4'h8, 4'h0, 4'h0);
    add(4'h8, 4'h0, 4'h8, 4'h8, 4'h8);
    add(4'h8, 4'h0, 4'h8, 4'h0, 4'h8);
    add(4'h8, 4'h0, 4'h8, 4'h0, 4'h8);
    add(4'h8, 4'h8, 4'h8, 4'h0, 4'h0);
    add(4'h8, 4'h0, 4'h8, 4'h0, 4'h0);
    // 8 -> 6 in one step; clear of bit 1 collides with its rising edge.
    for (int i = 0; i < 5; i++) add(4'h6, 4'h0, 4'h8, 4'h0, 4'h0);
    add(4'h6, 4'h0, 4'h6, 4'h0, 4'h0);
    add(4'h6, 4'h2, 4'h6, 4'h6, 4'h6);
    add(4'h6, 4'h0, 4'h6, 4'h0, 4'h6);
    add(4'h6, 4'hF, 4'h6, 4'h0, 4'h0);

    // Reset with busy inputs, then release and wait out the full debounce.
    sw_raw = 32'hA5A5_0001; btn_raw = 4'hF;
    repeat (3) tick();
    chk("reset_sw", io_sw, 32'h0);
    chk("reset_btn", 32'(io_btn), 32'h0);
    chk("reset_rise", 32'(btn_rise), 32'h0);
    chk("reset_evt", 32'(btn_evt), 32'h0);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e <= 5) begin
        chk("post_rst_sw_hold", io_sw, 32'h0);
        chk("post_rst_btn_hold", 32'(io_btn), 32'h0);
      end else if (e == 6) begin
        chk("post_rst_sw", io_sw, 32'hA5A5_0001);
        chk("post_rst_btn", 32'(io_btn), 32'hF);
        chk("post_rst_rise_late", 32'(btn_rise), 32'h0);
      end else begin
        chk("post_rst_rise", 32'(btn_rise), 32'hF);
        chk("post_rst_evt", 32'(btn_evt), 32'hF);
      end
    end
    btn_raw = '0; evt_clr = 4'hF;
    repeat (10) tick();
    evt_clr = '0;

    // Reset pulse four edges into a switch change drops the partial count.
    sw_raw = 32'h5A5A_0002;
    repeat (4) tick();
    chk("midrst_before", io_sw, 32'hA5A5_0001);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_async_sw", io_sw, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) chk("midrst_sw_hold", io_sw, 32'h0);
      if (e == 6) chk("midrst_sw", io_sw, 32'h5A5A_0002);
    end
    sw_raw = '0;
    repeat (10) tick();

    // Per-cycle button table.
    foreach (tbl[i]) begin
      btn_raw = tbl[i].btn;
      evt_clr = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_btn", i), 32'(io_btn), 32'(tbl[i].e_btn));
      chk($sformatf("tbl%0d_rise", i), 32'(btn_rise), 32'(tbl[i].e_rise));
      chk($sformatf("tbl%0d_evt", i), 32'(btn_evt), 32'(tbl[i].e_evt));
    end
    evt_clr = '0;

    // Random traffic: sparse bit flips with occasional holds, clears and one reset pulse.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) sw_raw = sw_raw ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(4) == 0) btn_raw = btn_raw ^ 4'($urandom);
      evt_clr = ($urandom_range(5) == 0) ? 4'($urandom) : 4'h0;
      rst_n = (i == 300) ? 1'b0 : 1'b1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
